// File: rtl/ipm2l_hsstlp_tx_lane_rst_fsm_v1_0.sv
// -----------------------------------------------------------------------------
// ipm2l_hsstlp_tx_lane_rst_fsm_v1_0
//
// TX lane reset sequencer for the HSSTLP lane. It waits for PLL done from the
// upstream PLL reset stage. It then releases lane powerdown, PMA TX reset and
// PCS TX reset in that order, with a timed hold at each step. Loss of PLL done
// or a user lane reset restarts the whole sequence.
//
// Optional feature (macro IPM2L_HSSTLP_TX_RATE_CHG_EN):
//   When defined, i_txrate is captured into P_TX_RATE on entry to LANE_PD.
//   A rate change seen in DONE runs a RATE_RST step (state 5), then PMA_RST
//   and PCS_RST again. When undefined, P_TX_RATE stays at TX_RATE_DEFAULT and
//   state 5 is never entered.
//
// Ports:
//   clk           in   free-running clock (same as PLL reset stage)
//   rst_n         in   asynchronous active-low reset
//   i_pll_done    in   PLL done, already in the clk domain
//   i_txlane_rst  in   user TX lane reset, active-high level
//   i_txrate      in   [1:0] requested TX rate
//   P_TX_LANE_PD  out  lane TX powerdown, active-high
//   P_TX_PMA_RST  out  PMA TX reset, active-high
//   P_PCS_TX_RST  out  PCS TX reset, active-high
//   P_TX_RATE     out  [1:0] TX rate to HSST
//   o_txlane_done out  lane TX up
//   o_fsm_st      out  [2:0] current state encoding (debug)
//
// Handshake: none. i_pll_done and i_txlane_rst are levels sampled every clk.
// -----------------------------------------------------------------------------
module ipm2l_hsstlp_tx_lane_rst_fsm_v1_0 #(
  parameter int         FREE_CLOCK_FREQ = 100,
  parameter int         PCS_RST_CYC     = 32,
  parameter logic [1:0] TX_RATE_DEFAULT = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pll_done,
  input  logic       i_txlane_rst,
  input  logic [1:0] i_txrate,
  output logic       P_TX_LANE_PD,
  output logic       P_TX_PMA_RST,
  output logic       P_PCS_TX_RST,
  output logic [1:0] P_TX_RATE,
  output logic       o_txlane_done,
  output logic [2:0] o_fsm_st
);

  // A timed state exits when the counter reaches N-1, so it lasts N cycles.
  localparam logic [15:0] LANE_PD_LAST = 16'(FREE_CLOCK_FREQ - 1);
  localparam logic [15:0] PMA_RST_LAST = 16'(2 * FREE_CLOCK_FREQ - 1);
  localparam logic [15:0] PCS_RST_LAST = 16'(PCS_RST_CYC - 1);
  localparam logic [15:0] RATE_RST_LAST = 16'(FREE_CLOCK_FREQ - 1);

  typedef enum logic [2:0] {
    ST_WAIT_PLL = 3'd0,
    ST_LANE_PD  = 3'd1,
    ST_PMA_RST  = 3'd2,
    ST_PCS_RST  = 3'd3,
    ST_DONE     = 3'd4,
    ST_RATE_RST = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  rate_q, rate_d;
  logic        pd_q, pma_q, pcs_q, done_q;
  logic        abort;

`ifndef IPM2L_HSSTLP_TX_RATE_CHG_EN
  logic unused_txrate;
  assign unused_txrate = ^i_txrate;
`endif

  assign abort = !i_pll_done || i_txlane_rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    rate_d  = rate_q;
    case (state_q)
      ST_WAIT_PLL: begin
        cnt_d = 16'd0;
        if (i_pll_done && !i_txlane_rst) begin
          state_d = ST_LANE_PD;
`ifdef IPM2L_HSSTLP_TX_RATE_CHG_EN
          rate_d  = i_txrate;
`endif
        end
      end
      ST_LANE_PD: if (cnt_q == LANE_PD_LAST) state_d = ST_PMA_RST;
      ST_PMA_RST: if (cnt_q == PMA_RST_LAST) state_d = ST_PCS_RST;
      ST_PCS_RST: if (cnt_q == PCS_RST_LAST) state_d = ST_DONE;
      ST_DONE: begin
        cnt_d = 16'd0;
`ifdef IPM2L_HSSTLP_TX_RATE_CHG_EN
        if (i_txrate != rate_q) begin
          state_d = ST_RATE_RST;
          rate_d  = i_txrate;
        end
`endif
      end
`ifdef IPM2L_HSSTLP_TX_RATE_CHG_EN
      ST_RATE_RST: if (cnt_q == RATE_RST_LAST) state_d = ST_PMA_RST;
`endif
      default: state_d = ST_WAIT_PLL;
    endcase

    // Abort wins over counter expiry and over a same-cycle rate change;
    // the rate register keeps its old value in that case.
    if (state_q != ST_WAIT_PLL && abort) begin
      state_d = ST_WAIT_PLL;
      rate_d  = rate_q;
    end

    // Counter restarts from zero on every state entry.
    if (state_d != state_q) cnt_d = 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_PLL;
      cnt_q   <= 16'd0;
      rate_q  <= TX_RATE_DEFAULT;
      pd_q    <= 1'b1;
      pma_q   <= 1'b1;
      pcs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      // Outputs decode the current state, so they trail the state by a cycle.
      case (state_q)
        ST_LANE_PD:  begin pd_q <= 1'b0; pma_q <= 1'b1; pcs_q <= 1'b1; done_q <= 1'b0; end
        ST_PMA_RST:  begin pd_q <= 1'b0; pma_q <= 1'b0; pcs_q <= 1'b1; done_q <= 1'b0; end
        ST_PCS_RST:  begin pd_q <= 1'b0; pma_q <= 1'b0; pcs_q <= 1'b0; done_q <= 1'b0; end
        ST_DONE:     begin pd_q <= 1'b0; pma_q <= 1'b0; pcs_q <= 1'b0; done_q <= 1'b1; end
        ST_RATE_RST: begin pd_q <= 1'b0; pma_q <= 1'b1; pcs_q <= 1'b1; done_q <= 1'b0; end
        default:     begin pd_q <= 1'b1; pma_q <= 1'b1; pcs_q <= 1'b1; done_q <= 1'b0; end
      endcase
    end
  end

  assign P_TX_LANE_PD  = pd_q;
  assign P_TX_PMA_RST  = pma_q;
  assign P_PCS_TX_RST  = pcs_q;
  assign P_TX_RATE     = rate_q;
  assign o_txlane_done = done_q;
  assign o_fsm_st      = state_q;

endmodule

// File: tb/tb_ipm2l_hsstlp_tx_lane_rst_fsm_v1_0.sv
// -----------------------------------------------------------------------------
// Bench for ipm2l_hsstlp_tx_lane_rst_fsm_v1_0 (FREE_CLOCK_FREQ=10, PCS_RST_CYC=32).
// The reference model tracks the lane as "cycles elapsed since the sequence
// started" and maps elapsed time onto the hold windows. Each stimulus cycle
// pushes the expected output vector {st, pd, pma, pcs, done, rate} into exp_q.
// A monitor pops and compares one vector after every clock edge.
// Build with +define+IPM2L_HSSTLP_TX_RATE_CHG_EN to model the rate-change build.
// -----------------------------------------------------------------------------
module tb_ipm2l_hsstlp_tx_lane_rst_fsm_v1_0;

  localparam int FREQ     = 10;
  localparam int PCS_CYC  = 32;
  localparam int PD_CYC   = FREQ;
  localparam int PMA_CYC  = 2 * FREQ;
  localparam int RATE_CYC = FREQ;
  localparam logic [1:0] RATE_DEF = 2'b00;
`ifdef IPM2L_HSSTLP_TX_RATE_CHG_EN
  localparam bit RATE_EN = 1'b1;
`else
  localparam bit RATE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_done = 1'b0;
  logic       lane_rst = 1'b0;
  logic [1:0] txrate = 2'b00;
  logic       pd, pma, pcs, done;
  logic [1:0] rate;
  logic [2:0] st;

  always #5 clk = ~clk;

  ipm2l_hsstlp_tx_lane_rst_fsm_v1_0 #(
    .FREE_CLOCK_FREQ(FREQ),
    .PCS_RST_CYC(PCS_CYC),
    .TX_RATE_DEFAULT(RATE_DEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_pll_done(pll_done),
    .i_txlane_rst(lane_rst),
    .i_txrate(txrate),
    .P_TX_LANE_PD(pd),
    .P_TX_PMA_RST(pma),
    .P_PCS_TX_RST(pcs),
    .P_TX_RATE(rate),
    .o_txlane_done(done),
    .o_fsm_st(st)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [8:0] dut_vec();
    return {st, pd, pma, pcs, done, rate};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got st=%0d pd/pma/pcs/done=%b rate=%b, expected st=%0d pd/pma/pcs/done=%b rate=%b",
               name, cyc, got[8:6], got[5:2], got[1:0], exp[8:6], exp[5:2], exp[1:0]);
    end
  endtask

  // Monitor: one output vector per clock edge while expectations are pending.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() > 0) check("scoreboard", dut_vec(), exp_q.pop_front());
  end

  // ---------------- reference model ----------------
  bit         m_run;   // sequence in progress (not waiting for PLL)
  int         m_t;     // cycles spent since the sequence (re)started
  bit         m_kind;  // 0: full start from powerdown, 1: rate-change restart
  logic [1:0] m_rate;

  // Map elapsed time onto the hold windows: 1=PD, 2=PMA, 3=PCS, 4=done, 5=rate.
  function automatic int phase(int t, bit kind);
    int lead;
    lead = kind ? RATE_CYC : PD_CYC;
    if (t < lead) return kind ? 5 : 1;
    if (t < lead + PMA_CYC) return 2;
    if (t < lead + PMA_CYC + PCS_CYC) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_kind = 1'b0; m_rate = RATE_DEF;
  endtask

  task automatic model_edge(input bit pll, input bit lrst, input logic [1:0] r);
    int cur, nxt;
    cur = m_run ? phase(m_t, m_kind) : 0;
    if (cur == 0) begin
      if (pll && !lrst) begin
        m_run = 1'b1; m_t = 0; m_kind = 1'b0;
        if (RATE_EN) m_rate = r;
      end
    end else if (!pll || lrst) begin
      m_run = 1'b0;
    end else if (cur == 4 && RATE_EN && r != m_rate) begin
      m_kind = 1'b1; m_t = 0; m_rate = r;
    end else begin
      m_t++;
    end
    nxt = m_run ? phase(m_t, m_kind) : 0;
    // Lane signals reflect the phase held during the cycle just finished.
    exp_q.push_back({3'(nxt), cur == 0, cur inside {0, 1, 5}, cur inside {0, 1, 2, 5},
                     cur == 4, m_rate});
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit pll, input bit lrst, input logic [1:0] r);
    @(negedge clk);
    pll_done = pll; lane_rst = lrst; txrate = r;
    model_edge(pll, lrst, r);
    @(posedge clk);
  endtask

  task automatic run(input int n, input bit pll, input bit lrst, input logic [1:0] r);
    for (int i = 0; i < n; i++) step(pll, lrst, r);
  endtask

  localparam logic [8:0] RESET_VEC = {3'd0, 4'b1110, RATE_DEF};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_held", dut_vec(), RESET_VEC);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_released", dut_vec(), RESET_VEC);

    // 1: basic bring-up; PD falls two cycles after pll_done goes high.
    run(5, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    #1 check("pd_still_high_T+1", {8'd0, pd}, 9'd1);
    step(1'b1, 1'b0, 2'b00);
    #1 check("pd_low_T+2", {8'd0, pd}, 9'd0);
    run(68, 1'b1, 1'b0, 2'b00);

    // 2: single-cycle pll_done glitch while in PMA_RST.
    step(1'b0, 1'b0, 2'b00);
    run(15, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    run(70, 1'b1, 1'b0, 2'b00);

    // 3: user lane reset held with pll_done high, then released.
    run(100, 1'b1, 1'b1, 2'b00);
    run(70, 1'b1, 1'b0, 2'b00);

    // 4: rate change while done.
    run(70, 1'b1, 1'b0, 2'b10);

    // 5: rate change coincident with pll_done loss -> abort wins.
    step(1'b0, 1'b0, 2'b01);
    run(70, 1'b1, 1'b0, 2'b01);

    // Randomized traffic: rare glitches, lane resets and rate changes.
    for (int i = 0; i < 3000; i++) begin
      bit pll_r, lrst_r;
      pll_r  = ($urandom_range(0, 199) != 0);
      lrst_r = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 299) == 0) txrate = 2'($urandom_range(0, 3));
      step(pll_r, lrst_r, txrate);
    end

    // 6: asynchronous reset in the middle of PCS_RST.
    step(1'b0, 1'b0, 2'b11);
    run(40, 1'b1, 1'b0, 2'b11);
    #3;
    check("in_pcs_rst", {6'd0, st}, 9'd3);
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), RESET_VEC);
    exp_q.delete();
    model_reset();
    pll_done = 1'b0; lane_rst = 1'b0; txrate = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_async_reset", dut_vec(), RESET_VEC);
    run(70, 1'b1, 1'b0, 2'b00);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 9'(exp_q.size()), 9'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
